// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: receiver state encoding, frame byte positions and default timings.
// The display formatter relies on the same byte positions.
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP = 4'd0,
        ST_START,
        ST_REL,
        ST_ACK_L,
        ST_ACK_H,
        ST_BIT_L,
        ST_BIT_H,
        ST_CHECK,
        ST_POLL
    } dht11_state_t;

    localparam int FRAME_W  = 40;
    localparam int BYTE_W   = 8;
    localparam int US_CNT_W = 21;

    localparam int HUM_INT_LSB = 32;
    localparam int HUM_DEC_LSB = 24;
    localparam int TMP_INT_LSB = 16;
    localparam int TMP_DEC_LSB = 8;
    localparam int CHKSUM_LSB  = 0;

    localparam int DEF_CLK_FREQ_MHZ = 50;
    localparam int DEF_POWERUP_US   = 1_000_000;
    localparam int DEF_START_US     = 20_000;
    localparam int DEF_POLL_US      = 2_000_000;
    localparam int DEF_TIMEOUT_US   = 200;
    localparam int DEF_BIT1_TH_US   = 50;

endpackage

// File: rtl/dht11_rx_us_tick_gen.sv
// Free-running 1 us tick: one-cycle pulse every CLK_FREQ_MHZ clock cycles.
module us_tick_gen
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
    input  logic clk,
    input  logic rst_n,
    output logic us_tick
);

    localparam int DIV_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ_MHZ - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            us_tick <= 1'b0;
        end else begin
            us_tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dht11_rx.sv
// DHT11 single-wire reader: start pulse, response/bit timing, 40-bit frame capture.
// Define DHT11_CHKSUM_EN to reject frames whose checksum byte does not match.
module dht11_rx
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
    parameter int POWERUP_US   = DEF_POWERUP_US,
    parameter int START_US     = DEF_START_US,
    parameter int POLL_US      = DEF_POLL_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter int BIT1_TH_US   = DEF_BIT1_TH_US
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    inout  wire                 dht11_data,
    output logic [FRAME_W-1:0]  t_h_data,
    output logic                data_valid,
    output logic                err
);

    localparam logic [US_CNT_W-1:0] POWERUP_CNT = US_CNT_W'(POWERUP_US);
    localparam logic [US_CNT_W-1:0] START_CNT   = US_CNT_W'(START_US);
    localparam logic [US_CNT_W-1:0] POLL_CNT    = US_CNT_W'(POLL_US);
    localparam logic [US_CNT_W-1:0] TIMEOUT_CNT = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0] BIT1_CNT    = US_CNT_W'(BIT1_TH_US);
    localparam logic [5:0]          LAST_BIT    = 6'(FRAME_W - 1);

    dht11_state_t         state;
    logic [US_CNT_W-1:0]  us_cnt;
    logic [5:0]           bit_cnt;
    logic [FRAME_W-1:0]   shift_reg;
    logic                 drive_low;
    logic                 us_tick;
    logic                 sync_p0;
    logic                 sync_p1;
    logic                 hist_p2;
    logic                 rise_p2;
    logic                 fall_p2;
    logic                 wait_state;
    logic                 timed_out;
    logic                 bit_val;

    function automatic logic chksum_ok(input logic [FRAME_W-1:0] f);
        logic [BYTE_W-1:0] sum;
        sum = f[HUM_INT_LSB +: BYTE_W] + f[HUM_DEC_LSB +: BYTE_W]
            + f[TMP_INT_LSB +: BYTE_W] + f[TMP_DEC_LSB +: BYTE_W];
        return sum == f[CHKSUM_LSB +: BYTE_W];
    endfunction

    // Open-drain: only ever pull low; the external resistor provides the high level.
    assign dht11_data = drive_low ? 1'b0 : 1'bz;

    us_tick_gen #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
    ) u_tick (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .us_tick(us_tick)
    );

    // Stages p0/p1: synchronizer; stage p2: registered edge pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            hist_p2 <= 1'b1;
            rise_p2 <= 1'b0;
            fall_p2 <= 1'b0;
        end else begin
            sync_p0 <= dht11_data;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            rise_p2 <= sync_p1 & ~hist_p2;
            fall_p2 <= ~sync_p1 & hist_p2;
        end
    end

    always_comb begin
        wait_state = 1'b0;
        case (state)
            ST_REL, ST_ACK_L, ST_ACK_H, ST_BIT_L, ST_BIT_H: wait_state = 1'b1;
            default: wait_state = 1'b0;
        endcase
    end

    // Any edge in the same cycle suppresses the timeout.
    assign timed_out = wait_state && !(rise_p2 || fall_p2) && (us_cnt > TIMEOUT_CNT);
    assign bit_val   = (us_cnt >= BIT1_CNT);

    always_ff @(posedge sys_clk) begin
        if (state == ST_BIT_H && fall_p2) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_POWERUP;
            us_cnt     <= '0;
            bit_cnt    <= '0;
            drive_low  <= 1'b0;
            t_h_data   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            err        <= 1'b0;

            if (rise_p2 || fall_p2) begin
                us_cnt <= '0;
            end else if (us_tick) begin
                us_cnt <= us_cnt + 1'b1;
            end

            if (timed_out) begin
                state  <= ST_POLL;
                us_cnt <= '0;
                err    <= 1'b1;
            end else begin
                unique case (state)
                    ST_POWERUP: begin
                        if (us_cnt >= POWERUP_CNT) begin
                            state     <= ST_START;
                            us_cnt    <= '0;
                            drive_low <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (us_cnt >= START_CNT) begin
                            state     <= ST_REL;
                            us_cnt    <= '0;
                            drive_low <= 1'b0;
                        end
                    end
                    ST_REL: begin
                        if (fall_p2) begin
                            state  <= ST_ACK_L;
                            us_cnt <= '0;
                        end
                    end
                    ST_ACK_L: begin
                        if (rise_p2) begin
                            state  <= ST_ACK_H;
                            us_cnt <= '0;
                        end
                    end
                    ST_ACK_H: begin
                        if (fall_p2) begin
                            state   <= ST_BIT_L;
                            us_cnt  <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    ST_BIT_L: begin
                        if (rise_p2) begin
                            state  <= ST_BIT_H;
                            us_cnt <= '0;
                        end
                    end
                    ST_BIT_H: begin
                        if (fall_p2) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            us_cnt  <= '0;
                            state   <= (bit_cnt == LAST_BIT) ? ST_CHECK : ST_BIT_L;
                        end
                    end
                    ST_CHECK: begin
`ifdef DHT11_CHKSUM_EN
                        if (chksum_ok(shift_reg)) begin
                            t_h_data   <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
`else
                        t_h_data   <= shift_reg;
                        data_valid <= 1'b1;
`endif
                        state  <= ST_POLL;
                        us_cnt <= '0;
                    end
                    ST_POLL: begin
                        if (us_cnt >= POLL_CNT) begin
                            state     <= ST_START;
                            us_cnt    <= '0;
                            drive_low <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_POWERUP;
                        us_cnt    <= '0;
                        drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht11_rx.sv
// Directed bench for dht11_rx with a behavioural DHT11 sensor on a pulled-up line.
`timescale 1ns/1ps
module tb_dht11_rx;

    localparam int CLK_MHZ = 2;
    localparam int HALF_NS = 250;
    localparam int US      = 1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        sen_low;
    wire         dht11_data;
    logic [39:0] t_h_data;
    logic        data_valid;
    logic        err;

    assign dht11_data = sen_low ? 1'b0 : 1'bz;
    pullup pu (dht11_data);

    always #HALF_NS sys_clk = ~sys_clk;

    dht11_rx #(
        .CLK_FREQ_MHZ(CLK_MHZ),
        .POWERUP_US  (100),
        .START_US    (20),
        .POLL_US     (200),
        .TIMEOUT_US  (200),
        .BIT1_TH_US  (50)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .dht11_data(dht11_data),
        .t_h_data  (t_h_data),
        .data_valid(data_valid),
        .err       (err)
    );

    int     n_checks = 0;
    int     n_errs   = 0;
    int     dv_cnt   = 0;
    int     err_cnt  = 0;
    longint err_time = 0;

    always @(negedge sys_clk) begin
        if (data_valid) dv_cnt <= dv_cnt + 1;
        if (err) begin
            err_cnt  <= err_cnt + 1;
            err_time <= $time;
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_line(input logic v, input int max_us, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_us * CLK_MHZ; c++) begin
            @(negedge sys_clk);
            if (dht11_data === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for the host start pulse, then answers with ACK and 40 bits MSB-first.
    task automatic sense_frame(input logic [39:0] frame, input int t0, input int t1,
                               input int stuck, input int abort_at);
        bit ok;
        wait_line(1'b0, 1000, ok);
        check_eq("sensor_sees_start", ok, 1);
        wait_line(1'b1, 100, ok);
        check_eq("sensor_sees_release", ok, 1);
        #(30 * US);
        sen_low = 1'b1;
        #(80 * US);
        sen_low = 1'b0;
        #(80 * US);
        for (int i = 0; i < 40; i++) begin
            sen_low = 1'b1;
            #(50 * US);
            sen_low = 1'b0;
            if (i == stuck) begin
                #(300 * US);
                return;
            end
            if (i == abort_at) begin
                #(10 * US);
                return;
            end
            #((frame[39-i] ? t1 : t0) * US);
        end
        sen_low = 1'b1;
        #(50 * US);
        sen_low = 1'b0;
    endtask

    task automatic measure_start(input longint t_ref);
        bit     ok;
        longint t_low;
        wait_line(1'b0, 300, ok);
        check_eq("start_seen", ok, 1);
        t_low = $time;
        check_rng("powerup_delay_ns", t_low - t_ref, 99000, 102500);
        wait_line(1'b1, 100, ok);
        check_eq("start_release_seen", ok, 1);
        check_rng("start_width_ns", $time - t_low, 19000, 23000);
    endtask

    typedef struct {
        logic [39:0] frame;
        int          t0;
        int          t1;
        int          stuck;
        logic [39:0] exp_data;
        int          exp_dv;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #(80_000 * US);
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit     ok;
        int     dv0;
        int     er0;
        longint t_ref;
        longint t_rel;

        vecs[0] = '{40'h3700190555, 27, 70, -1, 40'h3700190555, 1, 0};
`ifdef DHT11_CHKSUM_EN
        vecs[1] = '{40'h3700190556, 27, 70, -1, 40'h3700190555, 0, 1};
        vecs[2] = '{40'h3700190555, 27, 70, 17, 40'h3700190555, 0, 1};
`else
        vecs[1] = '{40'h3700190556, 27, 70, -1, 40'h3700190556, 1, 0};
        vecs[2] = '{40'h3700190555, 27, 70, 17, 40'h3700190556, 0, 1};
`endif
        vecs[3] = '{40'h2A00170344, 49, 51, -1, 40'h2A00170344, 1, 0};
        vecs[4] = '{40'h010203FA00, 27, 70, -1, 40'h010203FA00, 1, 0};

        sen_low   = 1'b0;
        sys_rst_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_eq("rst_t_h_data", t_h_data, 0);
        check_eq("rst_data_valid", data_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_line_released", dht11_data, 1);
        sys_rst_n = 1'b1;
        t_ref = $time;
        measure_start(t_ref);

        // No sensor: the first start pulse goes unanswered.
        t_rel = $time;
        er0   = err_cnt;
        ok    = 1'b0;
        for (int c = 0; c < 300 * CLK_MHZ; c++) begin
            @(negedge sys_clk);
            if (err_cnt != er0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("noresp_err_seen", ok, 1);
        check_rng("noresp_timeout_ns", err_time - t_rel, 200000, 205000);
        check_eq("noresp_no_valid", dv_cnt, 0);
        wait_line(1'b0, 400, ok);
        check_eq("noresp_next_start", ok, 1);
        check_rng("noresp_poll_gap_ns", $time - err_time, 198000, 202500);

        for (int i = 0; i < 5; i++) begin
            dv0 = dv_cnt;
            er0 = err_cnt;
            sense_frame(vecs[i].frame, vecs[i].t0, vecs[i].t1, vecs[i].stuck, -1);
            #(5 * US);
            check_eq($sformatf("vec%0d_data_valid_pulses", i), 64'(dv_cnt - dv0), 64'(vecs[i].exp_dv));
            check_eq($sformatf("vec%0d_err_pulses", i), 64'(err_cnt - er0), 64'(vecs[i].exp_err));
            check_eq($sformatf("vec%0d_t_h_data", i), t_h_data, vecs[i].exp_data);
        end

        // Reset in the middle of bit 20 of a transaction.
        sense_frame(40'h3700190555, 27, 70, -1, 20);
        sys_rst_n = 1'b0;
        #1;
        check_eq("midbit_rst_line", dht11_data, 1);
        check_eq("midbit_rst_t_h_data", t_h_data, 0);
        check_eq("midbit_rst_data_valid", data_valid, 0);
        check_eq("midbit_rst_err", err, 0);
        #(2 * US);
        sys_rst_n = 1'b1;
        t_ref = $time;
        measure_start(t_ref);

        // Reset while the host is holding the line low.
        wait_line(1'b0, 1000, ok);
        check_eq("start_seen_before_rst", ok, 1);
        #(3 * US);
        check_eq("line_low_in_start", dht11_data, 0);
        sys_rst_n = 1'b0;
        #1;
        check_eq("start_rst_line_released", dht11_data, 1);
        #(US);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dht11_rx.md
# dht11_rx

Single-wire DHT11 reader, upstream of the temperature/humidity display path. Periodically issues the DHT11 start pulse on the bidirectional data line, times the sensor's response and 40 data bits with a 1 µs tick, checks the checksum, and presents the frame as a 40-bit word. The word is laid out in the format the display formatter consumes: humidity int/dec, temperature int/dec, checksum.

## Interface
- `CLK_FREQ_MHZ`, 50: sys_clk frequency in MHz; sets the 1 µs tick divider.
- `POWERUP_US`, 1_000_000: idle time after reset before the first start pulse.
- `START_US`, 20_000: host low-pulse width.
- `POLL_US`, 2_000_000: idle gap between the end of one transaction and the next start pulse.
- `TIMEOUT_US`, 200: maximum duration of any single sensor-driven level.
- `BIT1_TH_US`, 50: a data-high level that lasts at least this long decodes as '1'; shorter decodes as '0'.
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `dht11_data` inout 1: open-drain sensor line with an external pull-up. The block only ever drives 0 or Z.
- `t_h_data` out 40: last good frame. [39:32] humidity int, [31:24] humidity dec, [23:16] temperature int, [15:8] temperature dec, [7:0] checksum.
- `data_valid` out 1: one-cycle pulse when `t_h_data` updates.
- `err` out 1: one-cycle pulse on timeout or checksum failure.

## Operation
- **Input conditioning.** `dht11_data` passes through a 2-FF synchronizer. Rise and fall edges are detected on the synchronized value.
- **Tick and counter.** `us_tick` pulses once every `CLK_FREQ_MHZ` cycles. `us_cnt` is 21 bits wide. It clears on every state entry and on every detected edge, and increments on `us_tick`.
- **States** (driven = the block pulls the line low):
  - POWERUP: wait `POWERUP_US`, then go to START.
  - START: line driven low. After `START_US`, release and go to REL.
  - REL: wait for a fall edge, then go to ACK_L.
  - ACK_L: wait for a rise edge, then go to ACK_H.
  - ACK_H: wait for a fall edge. Clear the bit count, then go to BIT_L.
  - BIT_L: wait for a rise edge, then go to BIT_H.
  - BIT_H: on a fall edge, shift in (`us_cnt` >= `BIT1_TH_US`) MSB-first and increment the bit count. If the count reaches 40, go to CHECK; otherwise go to BIT_L.
  - CHECK: one cycle. Evaluate the frame, then go to POLL.
  - POLL: wait `POLL_US`, then go to START.
- **Timeout.** In REL, ACK_L, ACK_H, BIT_L or BIT_H, `us_cnt` > `TIMEOUT_US` causes `err` to pulse and the FSM to go to POLL. `t_h_data` is left unchanged and the shift register is discarded.
- **Checksum.** (byte4 + byte3 + byte2 + byte1) mod 256 == byte0, computed in 8-bit wrap-around arithmetic.
- **Line drive.** `dht11_data` is 0 in START only and Z in every other state, including during reset.

## Timing
- **Reset values.** `t_h_data` = 0, `data_valid` = 0, `err` = 0, state = POWERUP, line = Z.
- **Input latency.** An edge on the pin is seen by the FSM 3 sys_clk cycles later (2 synchronizer stages plus 1 edge register).
- **Update latency.** `t_h_data` and `data_valid` update 1 cycle after the 40th bit's fall edge is detected (in CHECK, registered).
- **Simultaneous events.** When an edge and a timeout fire in the same cycle, the edge wins.
- **Reset mid-transaction.** An asynchronous reset releases the line immediately and restarts from POWERUP.
- **Tick accuracy.** The tick counter runs freely and is not resynchronized. Decode tolerance of ±1 µs is acceptable.

## Configuration
- `DHT11_CHKSUM_EN` defined:
  - In CHECK, a matching frame loads `t_h_data` and pulses `data_valid`.
  - A mismatching frame pulses `err` and leaves `t_h_data` unchanged.
- `DHT11_CHKSUM_EN` undefined:
  - Every complete 40-bit frame loads `t_h_data` and pulses `data_valid`.
  - The checksum byte is still stored.
  - `err` pulses only on timeout.

## Structure
- **Shared package `dht11_pkg`.** Holds the state encoding (9 states, 4-bit), the frame byte-position constants, and the default microsecond timing constants. The display formatter uses the same byte positions.
- **Sub-module `us_tick_gen`.** Parameterized by `CLK_FREQ_MHZ`; outputs the 1-cycle `us_tick`.
- **`dht11_rx` body.** Holds the synchronizer, edge detection, FSM, `us_cnt`, 40-bit shift register, bit counter and checksum.

## Test plan
The bench uses scaled parameters: `POWERUP_US`=100, `START_US`=20, `POLL_US`=200. A behavioural sensor model uses an 80 µs ACK low, 80 µs ACK high, 50 µs bit low, and a 27 µs ('0') or 70 µs ('1') bit high.

- **Reset.** Line stays Z until the first start pulse, then is low for exactly 20 µs ±1 tick. Outputs are 0 before the first frame.
- **Good frame.** Model sends 0x37_00_19_05_55 → `t_h_data` = 0x3700190555, one `data_valid` pulse, `err` never asserted.
- **Bad checksum.** Model sends 0x37_00_19_05_56:
  - With `DHT11_CHKSUM_EN`: `err` pulses and `t_h_data` holds its previous value.
  - Without it: `t_h_data` = 0x3700190556.
- **No sensor response.** Line stays high after release → `err` pulses at `TIMEOUT_US`, the FSM returns to POLL, and the next start pulse follows 200 µs later.
- **Stuck bit.** Model holds the line high for 300 µs at bit 17 → timeout `err` and no `data_valid`. The next good frame decodes correctly.
- **Threshold boundary.** A bit high of 49 µs decodes as 0; 51 µs decodes as 1. A reset asserted during bit 20 releases the line within the same cycle.
